// File: rtl/mdu_sched_pkg.sv
// Shared encodings for the multiply/divide scheduler: op codes, FSM states, divide length.
package mdu_sched_pkg;

    localparam logic [1:0] MDU_MULT  = 2'd0;
    localparam logic [1:0] MDU_MULTU = 2'd1;
    localparam logic [1:0] MDU_DIV   = 2'd2;
    localparam logic [1:0] MDU_DIVU  = 2'd3;

    // State names carry ST_ so they do not collide with the op code MDU_DIV.
    localparam logic [1:0] MDU_ST_IDLE = 2'd0;
    localparam logic [1:0] MDU_ST_MUL  = 2'd1;
    localparam logic [1:0] MDU_ST_DIV  = 2'd2;
    localparam logic [1:0] MDU_ST_DONE = 2'd3;

    localparam int unsigned MDU_DIV_STEPS = 32;

endpackage

// File: rtl/mdu_sched_div_step.sv
// One combinational restoring-divide iteration on unsigned magnitudes.
module mdu_sched_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        // One extra bit: the shifted remainder can reach 2*divisor-1.
        shifted  = {rem, quo[WIDTH-1]};
        fits     = shifted >= {1'b0, divisor};
        diff     = shifted[WIDTH-1:0] - divisor;
        rem_next = fits ? diff : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/mdu_sched.sv
// Multi-cycle MULT/MULTU/DIV/DIVU scheduler with pipeline stall and {HI,LO} write strobe.
// Optional abort input enabled by defining MDU_ANNUL_EN.
module mdu_sched
    import mdu_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef MDU_ANNUL_EN
    input  logic               annul,
`endif
    output logic               stall,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam logic [4:0] LastStep = 5'(MDU_DIV_STEPS - 1);

    logic [1:0]         state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic               sgn_q, sgn_d;
    logic               neg_q, neg_d;
    logic               rsgn_q, rsgn_d;
    logic               dz_q, dz_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic               annul_w;
    logic               signed_div;
    logic [WIDTH-1:0]   rem_n, quo_n, rem_fix, quo_fix;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;

`ifdef MDU_ANNUL_EN
    assign annul_w = annul;
`else
    assign annul_w = 1'b0;
`endif

    mdu_sched_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvsr_q),
        .rem_next (rem_n),
        .quo_next (quo_n)
    );

    always_comb begin
        ext_a   = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        ext_b   = sgn_q ? {{WIDTH{dvsr_q[WIDTH-1]}}, dvsr_q} : {{WIDTH{1'b0}}, dvsr_q};
        prod    = ext_a * ext_b;
        quo_fix = neg_q ? -quo_n : quo_n;
        rem_fix = rsgn_q ? -rem_n : rem_n;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        dvsr_d     = dvsr_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        sgn_d      = sgn_q;
        neg_d      = neg_q;
        rsgn_d     = rsgn_q;
        dz_d       = dz_q;
        result_d   = result_q;
        signed_div = (op == MDU_DIV);

        case (state_q)
            MDU_ST_IDLE: begin
                if (start && !annul_w) begin
                    case (op)
                        MDU_MULT, MDU_MULTU: begin
                            a_d     = a;
                            dvsr_d  = b;
                            sgn_d   = (op == MDU_MULT);
                            state_d = MDU_ST_MUL;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            a_d     = a;
                            quo_d   = (signed_div && a[WIDTH-1]) ? -a : a;
                            dvsr_d  = (signed_div && b[WIDTH-1]) ? -b : b;
                            rem_d   = '0;
                            cnt_d   = '0;
                            neg_d   = signed_div && (a[WIDTH-1] ^ b[WIDTH-1]);
                            rsgn_d  = signed_div && a[WIDTH-1];
                            dz_d    = (b == '0);
                            state_d = MDU_ST_DIV;
                        end
                        default: ;
                    endcase
                end
            end
            MDU_ST_MUL: begin
                if (annul_w) begin
                    state_d = MDU_ST_IDLE;
                end else begin
                    result_d = prod;
                    state_d  = MDU_ST_DONE;
                end
            end
            MDU_ST_DIV: begin
                if (annul_w) begin
                    state_d = MDU_ST_IDLE;
                end else begin
                    rem_d = rem_n;
                    quo_d = quo_n;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LastStep) begin
                        // Divide by zero bypasses the sign fix entirely.
                        result_d = dz_q ? {a_q, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
                        state_d  = MDU_ST_DONE;
                    end
                end
            end
            default: state_d = MDU_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MDU_ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            dvsr_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            sgn_q    <= 1'b0;
            neg_q    <= 1'b0;
            rsgn_q   <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            dvsr_q   <= dvsr_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            sgn_q    <= sgn_d;
            neg_q    <= neg_d;
            rsgn_q   <= rsgn_d;
            dz_q     <= dz_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        stall  = ((state_q == MDU_ST_IDLE && start) || state_q == MDU_ST_MUL ||
                  state_q == MDU_ST_DIV) && !annul_w;
        done   = (state_q == MDU_ST_DONE) && !annul_w;
        result = result_q;
    end

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched: latency, stall length, results, back-to-back, reset/annul abort.
module tb_mdu_sched;
    import mdu_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic        done;
    logic [63:0] result;
`ifdef MDU_ANNUL_EN
    logic        annul;
`endif

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    int exp_dones = 0;
    int cyc = 0;
    int t1, t2, dc_before;

    mdu_sched #(
        .WIDTH (32)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
`ifdef MDU_ANNUL_EN
        .annul  (annul),
`endif
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_count <= done_count + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts an op in the current cycle and holds start until done; operands are
    // scrambled after the first cycle since they must only be sampled in IDLE.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] exp_res, input int exp_lat,
                         output int done_at);
        int  n = 0;
        int  stalls = 0;
        int  lat = -1;
        bit  got = 0;
        done_at = -1;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        while (!got && n < 60) begin
            @(negedge clk);
            if (done) begin
                got     = 1;
                lat     = n;
                done_at = cyc;
                check({tag, " stall at done"}, {63'd0, stall}, 64'd0);
            end else begin
                if (stall) stalls++;
                tick();
                n++;
                a  = ~a;
                b  = ~b;
                op = ~op;
            end
        end
        exp_dones++;
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " stall cycles"}, stalls, exp_lat);
        check({tag, " result"}, result, exp_res);
    endtask

    // Cycle after DONE with start dropped: idle, no second done, result held.
    task automatic post(input string tag, input logic [63:0] exp_res);
        tick();
        start = 1'b0;
        @(negedge clk);
        check({tag, " idle done"}, {63'd0, done}, 64'd0);
        check({tag, " idle stall"}, {63'd0, stall}, 64'd0);
        check({tag, " held result"}, result, exp_res);
        check({tag, " done pulses"}, done_count, exp_dones);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = MDU_MULT;
        a     = '0;
        b     = '0;
`ifdef MDU_ANNUL_EN
        annul = 1'b0;
`endif
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset stall", {63'd0, stall}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset result", result, 64'd0);

        tick();
        do_op("mult", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 2, t1);
        post("mult", 64'hFFFF_FFFF_FFFF_FFFA);

        tick();
        do_op("multu", MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, 2, t1);
        post("multu", 64'h0000_0002_FFFF_FFFA);

        tick();
        do_op("divu", MDU_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 33, t1);
        post("divu", 64'h0000_0002_0000_000E);

        tick();
        do_op("div neg a", MDU_DIV, 32'hFFFF_FF9C, 32'd7, 64'hFFFF_FFFE_FFFF_FFF2, 33, t1);
        post("div neg a", 64'hFFFF_FFFE_FFFF_FFF2);

        tick();
        do_op("div neg b", MDU_DIV, 32'd100, 32'hFFFF_FFF9, 64'h0000_0002_FFFF_FFF2, 33, t1);
        post("div neg b", 64'h0000_0002_FFFF_FFF2);

        tick();
        do_op("div by zero", MDU_DIV, 32'h1234_5678, 32'd0, 64'h1234_5678_FFFF_FFFF, 33, t1);
        post("div by zero", 64'h1234_5678_FFFF_FFFF);

        tick();
        do_op("div ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33,
              t1);
        post("div ovf", 64'h0000_0000_8000_0000);

        // Second op presented in the cycle right after DONE.
        tick();
        do_op("b2b first", MDU_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 33, t1);
        tick();
        do_op("b2b second", MDU_DIVU, 32'hFFFF_FFFF, 32'h10, 64'h0000_000F_0FFF_FFFF, 33, t2);
        post("b2b", 64'h0000_000F_0FFF_FFFF);
        check("b2b done spacing", t2 - t1, 34);

        // Reset during divide step 10 (cycle T+11).
        tick();
        start = 1'b1;
        op    = MDU_DIV;
        a     = 32'd100;
        b     = 32'd7;
        for (int i = 0; i < 11; i++) tick();
        dc_before = done_count;
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("pre-reset stall", {63'd0, stall}, 64'd1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid-op reset stall", {63'd0, stall}, 64'd0);
        check("mid-op reset result", result, 64'd0);
        for (int i = 0; i < 40; i++) tick();
        check("mid-op reset no done", done_count, dc_before);

`ifdef MDU_ANNUL_EN
        tick();
        do_op("pre-annul mult", MDU_MULT, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 2, t1);
        post("pre-annul mult", 64'h0000_0000_0000_000F);
        tick();
        start = 1'b1;
        op    = MDU_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        for (int i = 0; i < 11; i++) tick();
        dc_before = done_count;
        annul = 1'b1;
        @(negedge clk);
        check("annul stall", {63'd0, stall}, 64'd0);
        check("annul done", {63'd0, done}, 64'd0);
        tick();
        annul = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        check("annul no done", done_count, dc_before);
        check("annul result kept", result, 64'h0000_0000_0000_000F);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
